rx_sync_demux: RTL and testbench
================================

Name: rx_sync_demux

Overview:
Receive-side front end placed directly upstream of the dual-FIFO device stage. It samples one 10-bit symbol per clk and acquires symbol sync on consecutive COM (0x0BC) symbols. It strips COM/IDL control symbols and steers data bytes alternately into lane 0 and lane 1 using the FIFO write strobes. It also supervises loss of sync and lane overflow.

Parameters:
DATA_SIZE, 10, input symbol width
MAIN_SIZE, 8, data byte width (in[7:0])
COM_COUNT, 4, consecutive COM symbols required to declare sync
ERR_LIMIT, 4, consecutive invalid symbols that drop sync
COM_SYM, 10'h0BC, comma/alignment symbol
IDL_SYM, 10'h07C, idle symbol

Ports:
clk  input  1  symbol clock; all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
in  input  DATA_SIZE  incoming symbol, one per clk
full0  input  1  lane-0 FIFO full
full1  input  1  lane-1 FIFO full
data_out  output  MAIN_SIZE  byte presented to both FIFOs
write0  output  1  write strobe lane 0
write1  output  1  write strobe lane 1
active  output  1  sync acquired
sym_error  output  1  one-cycle pulse, invalid symbol while active
overflow0  output  1  one-cycle pulse, lane-0 byte dropped (full0)
overflow1  output  1  one-cycle pulse, lane-1 byte dropped (full1)

Behaviour:
- Symbol classes: in==COM_SYM -> COM; in==IDL_SYM -> IDL; in[9:8]==2'b00 and not COM/IDL -> DATA (byte in[7:0]); in[9:8]!=2'b00 -> INVALID.
- All outputs registered. Response appears on the clk edge after in is sampled (latency 1).
- Reset (reset==0 at posedge): state=SEARCH, com_cnt=0, err_cnt=0, lane_ptr=0. All outputs 0, data_out=0. Applies mid-operation with no partial writes.
- FSM SEARCH: active=0, write0/1=0.
  - COM increments com_cnt (saturating). A non-COM clears it.
  - When a COM brings com_cnt to COM_COUNT -> SYNC. active=1 from the next edge. lane_ptr=0 and err_cnt=0 on entry.
- FSM SYNC: active=1.
  - COM and IDL are discarded (no write) and clear err_cnt.
  - DATA clears err_cnt, drives data_out=in[7:0], and targets lane lane_ptr.
    - If that lane is not full: its write strobe is 1 for exactly one cycle.
    - If full: no write, and the corresponding overflow pulse fires.
    - lane_ptr toggles after every DATA symbol, written or dropped, to keep byte pairing.
  - INVALID: sym_error=1 for one cycle, no write, err_cnt++.
    - When err_cnt reaches ERR_LIMIT -> SEARCH. active=0 on that edge, com_cnt=0, lane_ptr=0.
- write0 and write1 are never 1 in the same cycle.
- data_out holds its last value when no write occurs.
- full0/full1 are sampled in the same cycle as the DATA symbol.
- Counters saturate and never wrap.

Test Plan:
- Reset held 0 for 6 clk with in=0x3FF -> all outputs 0, active=0. Release reset, then 3 BC + 0x0FF + 3 BC -> active stays 0 (count restarts).
- 4 consecutive 0x0BC -> active=1 on the edge after the 4th BC. 5th BC and 5× 0x07C -> no write strobes.
- Active, full0=full1=0, in=0x0FF,0x0EE,0x0BB,0x011 -> write0 with data_out=FF, write1 EE, write0 BB, write1 11, each one cycle at latency 1.
- Active, full1=1, in=0x0AA,0x055,0x033 -> write0 AA; overflow1 pulse, no write1; write0 33 (pointer still toggled).
- Active, in=0x3FF ×3, 0x07C, 0x3FF ×4 -> sym_error pulses on each 3FF, active stays 1 after the first three. active drops to 0 on the 4th consecutive 3FF. A subsequent 4 BC re-acquires sync with lane_ptr=0.
- Active with data streaming, then reset=0 for 1 clk -> next edge all outputs 0, state SEARCH, no residual write strobe.

Source files
------------

// File: rtl/rx_sync_demux.sv
// rx_sync_demux: symbol sync acquisition and two-lane byte demux for a dual-FIFO stage
// Ports: clk/reset (sync, active-low); in = 10-bit symbol per clk; full0/full1 = lane FIFO full;
// data_out = byte for both FIFOs; write0/write1 = lane write strobes; active = sync held;
// sym_error = invalid symbol while active; overflow0/overflow1 = byte dropped on a full lane.
module rx_sync_demux #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int COM_COUNT = 4,
  parameter int ERR_LIMIT = 4,
  parameter logic [DATA_SIZE-1:0] COM_SYM = 10'h0BC,
  parameter logic [DATA_SIZE-1:0] IDL_SYM = 10'h07C
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 full0,
  input  logic                 full1,
  output logic [MAIN_SIZE-1:0] data_out,
  output logic                 write0,
  output logic                 write1,
  output logic                 active,
  output logic                 sym_error,
  output logic                 overflow0,
  output logic                 overflow1
);
  localparam int CW = $clog2(COM_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  typedef enum logic {SEARCH, SYNC} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic lane_q, lane_d;
  logic [MAIN_SIZE-1:0] data_q, data_d;
  logic wr0_q, wr0_d, wr1_q, wr1_d, serr_q, serr_d, ovf0_q, ovf0_d, ovf1_q, ovf1_d;
  logic is_com, is_idl, is_data, is_inv;
  assign is_com  = in == COM_SYM;
  assign is_idl  = in == IDL_SYM;
  assign is_inv  = in[DATA_SIZE-1:MAIN_SIZE] != '0;
  assign is_data = !is_inv && !is_com && !is_idl;
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    err_cnt_d = err_cnt_q;
    lane_d    = lane_q;
    data_d    = data_q;
    wr0_d     = 1'b0;
    wr1_d     = 1'b0;
    serr_d    = 1'b0;
    ovf0_d    = 1'b0;
    ovf1_d    = 1'b0;
    if (state_q == SEARCH) begin
      // the transition happens on the COUNT-th comma, so the counter never passes COM_COUNT-1
      if (is_com && com_cnt_q == CW'(COM_COUNT - 1)) begin
        state_d   = SYNC;
        com_cnt_d = '0;
        err_cnt_d = '0;
        lane_d    = 1'b0;
      end else begin
        com_cnt_d = is_com ? com_cnt_q + 1'b1 : '0;
      end
    end else if (is_inv) begin
      serr_d = 1'b1;
      if (err_cnt_q == EW'(ERR_LIMIT - 1)) begin
        state_d   = SEARCH;
        err_cnt_d = '0;
        com_cnt_d = '0;
        lane_d    = 1'b0;
      end else begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else begin
      err_cnt_d = '0;
      if (is_data) begin
        // pointer advances even on a dropped byte so lane pairing is preserved
        lane_d = !lane_q;
        wr0_d  = !lane_q && !full0;
        wr1_d  = lane_q && !full1;
        ovf0_d = !lane_q && full0;
        ovf1_d = lane_q && full1;
        data_d = (wr0_d || wr1_d) ? in[MAIN_SIZE-1:0] : data_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SEARCH;
      com_cnt_q <= '0;
      err_cnt_q <= '0;
      lane_q    <= 1'b0;
      data_q    <= '0;
      wr0_q     <= 1'b0;
      wr1_q     <= 1'b0;
      serr_q    <= 1'b0;
      ovf0_q    <= 1'b0;
      ovf1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      err_cnt_q <= err_cnt_d;
      lane_q    <= lane_d;
      data_q    <= data_d;
      wr0_q     <= wr0_d;
      wr1_q     <= wr1_d;
      serr_q    <= serr_d;
      ovf0_q    <= ovf0_d;
      ovf1_q    <= ovf1_d;
    end
  end
  assign data_out  = data_q;
  assign write0    = wr0_q;
  assign write1    = wr1_q;
  assign active    = state_q == SYNC;
  assign sym_error = serr_q;
  assign overflow0 = ovf0_q;
  assign overflow1 = ovf1_q;
endmodule

// File: tb/tb_rx_sync_demux.sv
// tb_rx_sync_demux: directed vector table plus randomized run against a behavioural model
module tb_rx_sync_demux;
  logic clk = 0, reset = 0, full0 = 0, full1 = 0;
  logic [9:0] in = 10'h3FF;
  logic [7:0] data_out;
  logic write0, write1, active, sym_error, overflow0, overflow1;
  int total = 0, bad = 0;
  rx_sync_demux dut (
    .clk(clk), .reset(reset), .in(in), .full0(full0), .full1(full1),
    .data_out(data_out), .write0(write0), .write1(write1), .active(active),
    .sym_error(sym_error), .overflow0(overflow0), .overflow1(overflow1)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       r;
    logic [9:0] s;
    logic [1:0] f;
    logic [7:0] d;
    logic [5:0] fl;
  } vec_t;
  vec_t vq[$];
  bit m_sync = 0;
  int m_com = 0, m_err = 0, m_lane = 0;
  logic [7:0] m_data = 0;
  task automatic add(input logic r, input logic [9:0] s, input logic [1:0] f, input logic [7:0] d, input logic [5:0] fl);
    vq.push_back('{r, s, f, d, fl});
  endtask
  task automatic model(input logic r, input logic [9:0] s, input logic f0, input logic f1, output logic [13:0] e);
    logic w0 = 0, w1 = 0, se = 0, o0 = 0, o1 = 0;
    if (!r) begin
      m_sync = 0; m_com = 0; m_err = 0; m_lane = 0; m_data = 0;
    end else if (!m_sync) begin
      m_com = (s == 10'h0BC) ? m_com + 1 : 0;
      if (m_com == 4) begin m_sync = 1; m_com = 0; m_err = 0; m_lane = 0; end
    end else if (s == 10'h0BC || s == 10'h07C) begin
      m_err = 0;
    end else if (s[9:8] == 2'b00) begin
      m_err = 0;
      if ((m_lane == 0 ? f0 : f1)) begin
        if (m_lane == 0) o0 = 1; else o1 = 1;
      end else begin
        if (m_lane == 0) w0 = 1; else w1 = 1;
        m_data = s[7:0];
      end
      m_lane = 1 - m_lane;
    end else begin
      se = 1;
      m_err++;
      if (m_err == 4) begin m_sync = 0; m_com = 0; m_lane = 0; m_err = 0; end
    end
    e = {m_data, w0, w1, m_sync, se, o0, o1};
  endtask
  task automatic check(input string nm, input int idx, input logic [13:0] got, input logic [13:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s #%0d got data=%h w0w1 act serr ov0ov1=%b want data=%h flags=%b",
               nm, idx, got[13:6], got[5:0], exp[13:6], exp[5:0]);
    end
  endtask
  task automatic step(input logic r, input logic [9:0] s, input logic f0, input logic f1, output logic [13:0] got, output logic [13:0] e);
    @(negedge clk);
    reset = r; in = s; full0 = f0; full1 = f1;
    @(posedge clk);
    #1;
    got = {data_out, write0, write1, active, sym_error, overflow0, overflow1};
    model(r, s, f0, f1, e);
  endtask
  initial begin
    logic [13:0] got, e;
    repeat (6) add(0, 10'h3FF, 2'b00, 8'h00, 6'b000000);
    repeat (3) add(1, 10'h0BC, 2'b00, 8'h00, 6'b000000);
    add(1, 10'h0FF, 2'b00, 8'h00, 6'b000000);
    repeat (3) add(1, 10'h0BC, 2'b00, 8'h00, 6'b000000);
    add(1, 10'h07C, 2'b00, 8'h00, 6'b000000);
    repeat (3) add(1, 10'h0BC, 2'b00, 8'h00, 6'b000000);
    add(1, 10'h0BC, 2'b00, 8'h00, 6'b001000);
    add(1, 10'h0BC, 2'b00, 8'h00, 6'b001000);
    repeat (5) add(1, 10'h07C, 2'b00, 8'h00, 6'b001000);
    add(1, 10'h0FF, 2'b00, 8'hFF, 6'b101000);
    add(1, 10'h0EE, 2'b00, 8'hEE, 6'b011000);
    add(1, 10'h0BB, 2'b00, 8'hBB, 6'b101000);
    add(1, 10'h011, 2'b00, 8'h11, 6'b011000);
    add(1, 10'h0AA, 2'b01, 8'hAA, 6'b101000);
    add(1, 10'h055, 2'b01, 8'hAA, 6'b001001);
    add(1, 10'h033, 2'b01, 8'h33, 6'b101000);
    repeat (3) add(1, 10'h3FF, 2'b00, 8'h33, 6'b001100);
    add(1, 10'h07C, 2'b00, 8'h33, 6'b001000);
    repeat (3) add(1, 10'h3FF, 2'b00, 8'h33, 6'b001100);
    add(1, 10'h3FF, 2'b00, 8'h33, 6'b000100);
    add(1, 10'h3FF, 2'b00, 8'h33, 6'b000000);
    repeat (3) add(1, 10'h0BC, 2'b00, 8'h33, 6'b000000);
    add(1, 10'h0BC, 2'b00, 8'h33, 6'b001000);
    add(1, 10'h012, 2'b00, 8'h12, 6'b101000);
    add(1, 10'h034, 2'b00, 8'h34, 6'b011000);
    add(1, 10'h099, 2'b10, 8'h34, 6'b001010);
    add(1, 10'h056, 2'b00, 8'h56, 6'b011000);
    add(0, 10'h078, 2'b00, 8'h00, 6'b000000);
    add(1, 10'h000, 2'b00, 8'h00, 6'b000000);
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].s, vq[i].f[1], vq[i].f[0], got, e);
      check("vector", i, got, {vq[i].d, vq[i].fl});
      check("vec_model", i, got, e);
    end
    for (int i = 0; i < 600; i++) begin
      logic r, f0, f1;
      logic [9:0] s;
      int k;
      r = $urandom_range(0, 59) != 0;
      k = $urandom_range(0, 99);
      if (k < (m_sync ? 15 : 80)) s = 10'h0BC;
      else if (k < (m_sync ? 25 : 85)) s = 10'h07C;
      else if (k < 88) s = {2'($urandom_range(1, 3)), 8'($urandom)};
      else s = {2'b00, 8'($urandom)};
      if (m_sync && $urandom_range(0, 9) == 0) s = {2'($urandom_range(1, 3)), 8'($urandom)};
      f0 = $urandom_range(0, 3) == 0;
      f1 = $urandom_range(0, 3) == 0;
      step(r, s, f0, f1, got, e);
      check("random", i, got, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
